uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter ACK_TIMEOUT, default 1024, clock cycles to wait for pc_ack per byte.
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port uart_rxd  input  1  asynchronous serial line from PC, idle high.
REQ-007 Port pc_cmd_valid  output  1  one-cycle strobe, byte on pc_cmd_data valid; feeds the config parser.
REQ-008 Port pc_cmd_data  output  8  received command byte.
REQ-009 Port pc_ack  input  1  byte accepted by the config parser.
REQ-010 Port frame_err  output  1  one-cycle pulse on bad stop bit (or parity, see Configuration).
REQ-011 Port overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 Port ack_timeout  output  1  one-cycle pulse when ACK_TIMEOUT expires without pc_ack.

Function
REQ-013 uart_rxd SHALL pass a 2-flop synchronizer before use; falling-edge detect on the synchronized signal.
REQ-014 Oversample tick SHALL pulse once every DIV = floor(CLK_FREQ_HZ/(BAUD*16)) cycles (minimum 1); free-running, restarted on start-edge detect.
REQ-015 Receive FSM states: IDLE, START, DATA, [PARITY], STOP; 8 data bits, LSB first.
REQ-016 IDLE -> START on synchronized falling edge.
REQ-017 START: at tick 8 sample line; low -> DATA; high -> IDLE (glitch, no error pulse).
REQ-018 DATA: sample each bit 16 ticks after previous sample; after bit 7 -> STOP (or PARITY).
REQ-019 STOP: sample 16 ticks later; high -> push byte, IDLE; low -> frame_err pulse, byte discarded, IDLE.
REQ-020 Byte FIFO SHALL be 4 entries deep, first-in first-out.
REQ-021 Push while full SHALL drop the new byte and pulse overflow; FIFO contents unchanged.
REQ-022 Push and pop in the same cycle while full SHALL both succeed (pop first); no overflow.
REQ-023 Output FSM states: OUT_IDLE, OUT_WAIT.
REQ-024 OUT_IDLE with FIFO non-empty: pop, drive pc_cmd_data, pc_cmd_valid high exactly one cycle, -> OUT_WAIT.
REQ-025 OUT_WAIT: pc_ack high -> OUT_IDLE; pc_ack ignored in the valid cycle itself.
REQ-026 OUT_WAIT: ACK_TIMEOUT cycles elapsed without pc_ack -> ack_timeout pulse, byte abandoned, OUT_IDLE.
REQ-027 pc_cmd_data SHALL hold the last issued byte until the next pc_cmd_valid.
REQ-028 Minimum spacing between consecutive pc_cmd_valid pulses: 2 cycles.

Reset
REQ-029 rst_n low SHALL asynchronously force: both FSMs to IDLE/OUT_IDLE, FIFO empty, synchronizer flops to 1, counters to 0.
REQ-030 Output reset values: pc_cmd_valid 0, pc_cmd_data 8'h00, frame_err 0, overflow 0, ack_timeout 0.
REQ-031 Reset mid-frame SHALL discard the partial byte; no pulse on any output after release until a new full frame completes.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: frame 8E1, PARITY state between DATA and STOP samples the 9th bit; even-parity mismatch -> frame_err pulse, byte discarded, IDLE (no STOP sample).
REQ-033 Macro UART_RX_PARITY_EN undefined: frame 8N1, no PARITY state, no parity logic.

Verification (CLK_FREQ_HZ=1600000, BAUD=100000, DIV=1, 16 clk/bit, 8N1 unless noted)
REQ-034 Frame 0xA5, pc_ack 3 cycles after valid -> one pc_cmd_valid with data 8'hA5, no error pulses.
REQ-035 Frames 0x01..0x06 back-to-back, pc_ack held 0 until all received, then ack each after 1 cycle -> valid carries 0x01,0x02,0x03,0x04,0x05 in order; overflow pulses exactly once, for 0x06.
REQ-036 Frame 0x3C with stop bit low -> frame_err one pulse; no pc_cmd_valid.
REQ-037 3-cycle low glitch on idle line -> no state change, no outputs.
REQ-038 Frame 0x5A, pc_ack never asserted, ACK_TIMEOUT=16 -> valid once, ack_timeout pulse 16 cycles later, FSM back to OUT_IDLE.
REQ-039 rst_n low during bit 4 of 0xFF, then frame 0x81 -> only 0x81 delivered; with UART_RX_PARITY_EN, 0x81 with parity bit 1 -> frame_err, no valid.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// Receives command bytes from a PC over an asynchronous serial line and
// presents them one at a time to the config parser with a valid/ack
// handshake. Received bytes are buffered in a 4-entry FIFO.
//
// Ports:
//   clk          - system clock, all logic on the rising edge
//   rst_n        - asynchronous active-low reset
//   uart_rxd     - serial input from the PC, idle high
//   pc_cmd_valid - one-cycle strobe, pc_cmd_data holds a new byte
//   pc_cmd_data  - last issued command byte (held until the next strobe)
//   pc_ack       - parser accepted the byte
//   frame_err    - one-cycle pulse on a bad stop bit (or bad parity)
//   overflow     - one-cycle pulse when a good byte is dropped (FIFO full)
//   ack_timeout  - one-cycle pulse when pc_ack never arrived for a byte
//
// Build option: define UART_RX_PARITY_EN for 8E1 framing with even-parity
// checking; without it the frame is 8N1.
module uart_cmd_rx #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic       pc_cmd_valid,
    output logic [7:0] pc_cmd_data,
    input  logic       pc_ack,
    output logic       frame_err,
    output logic       overflow,
    output logic       ack_timeout
);
    localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam int TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] RX_PARITY = 3'd4;
    localparam logic [2:0] RX_AFTER_DATA = RX_PARITY;
`else
    localparam logic [2:0] RX_AFTER_DATA = RX_STOP;
`endif

    localparam logic OUT_IDLE = 1'b0;
    localparam logic OUT_WAIT = 1'b1;

    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic             start_edge, tick;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       rx_state_q, rx_state_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_push;
    logic             frame_err_q, frame_err_d;

    logic [7:0]       fifo_mem_q [4];
    logic [1:0]       wr_ptr_q, rd_ptr_q;
    logic [2:0]       count_q;
    logic             fifo_full, fifo_pop, push_ok;
    logic             overflow_q, overflow_d;

    logic             out_state_q, out_state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             ack_to_q, ack_to_d;

    // Two-flop synchronizer plus one history flop for falling-edge detect.
    // All three reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Start edges only matter while idle; data-bit transitions are ignored.
    assign start_edge = (rx_state_q == RX_IDLE) && rxd_prev_q && !rxd_sync_q;
    assign tick       = (div_cnt_q == DIV_LAST);

    // The oversample divider is re-phased on every start edge so the
    // mid-bit sample points line up with the incoming frame.
    always_comb begin
        if (start_edge || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // Receive FSM: sample at the middle of the start bit (tick 8), then every
    // 16 ticks for each data bit, the optional parity bit and the stop bit.
    always_comb begin
        rx_state_d  = rx_state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_push     = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (start_edge) begin
                    rx_state_d = RX_START;
                    tick_cnt_d = 4'd0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = 4'd0;
                        bit_cnt_d  = 3'd0;
                        rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d = {rxd_sync_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            rx_state_d = RX_AFTER_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        // Even parity: data bits plus parity bit hold an even
                        // number of ones. A mismatch skips the stop sample.
                        if (^{shift_q, rxd_sync_q}) begin
                            frame_err_d = 1'b1;
                            rx_state_d  = RX_IDLE;
                        end else begin
                            rx_state_d  = RX_STOP;
                        end
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        rx_push     = rxd_sync_q;
                        frame_err_d = !rxd_sync_q;
                        rx_state_d  = RX_IDLE;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            rx_state_q  <= RX_IDLE;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            rx_state_q  <= rx_state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds when the output side is draining.
    assign fifo_full  = (count_q == 3'd4);
    assign push_ok    = rx_push && (!fifo_full || fifo_pop);
    assign overflow_d = rx_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q    <= count_q + {2'b00, push_ok} - {2'b00, fifo_pop};
            overflow_q <= overflow_d;
        end
    end

    // Output FSM: issue one byte, then wait for pc_ack (not counted in the
    // strobe cycle itself) or give up after ACK_TIMEOUT cycles.
    always_comb begin
        out_state_d = out_state_q;
        to_cnt_d    = to_cnt_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        ack_to_d    = 1'b0;
        fifo_pop    = 1'b0;
        if (out_state_q == OUT_WAIT) begin
            if (pc_ack && !valid_q) begin
                out_state_d = OUT_IDLE;
            end else if (to_cnt_q == TO_LAST) begin
                ack_to_d    = 1'b1;
                out_state_d = OUT_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else if (count_q != 3'd0) begin
            fifo_pop    = 1'b1;
            data_d      = fifo_mem_q[rd_ptr_q];
            valid_d     = 1'b1;
            to_cnt_d    = '0;
            out_state_d = OUT_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q <= OUT_IDLE;
            to_cnt_q    <= '0;
            valid_q     <= 1'b0;
            data_q      <= 8'h00;
            ack_to_q    <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            to_cnt_q    <= to_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            ack_to_q    <= ack_to_d;
        end
    end

    assign pc_cmd_valid = valid_q;
    assign pc_cmd_data  = data_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;
    assign ack_timeout  = ack_to_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx
// Self-checking bench for uart_cmd_rx at 16 clocks per bit. A main DUT
// (long ack timeout) is driven with a table of frames, hand-written corner
// sequences and a random frame stream checked against a queue model. A
// second DUT with a 16-cycle ack timeout and pc_ack tied low shares the
// serial line and is used for the timeout sequence.
module tb_uart_cmd_rx;
    localparam int CLK_FREQ_HZ = 1600000;
    localparam int BAUD        = 100000;
    localparam int BIT_CYC     = 16;
    localparam int TO_SHORT    = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rxd;
    logic       pc_ack;
    logic       ackTo;
    logic       pc_cmd_valid;
    logic [7:0] pc_cmd_data;
    logic       frame_err;
    logic       overflow;
    logic       ack_timeout;
    logic       toValid;
    logic [7:0] toData;
    logic       toFerr;
    logic       toOvf;
    logic       toTimeout;

    int nVec = 0;
    int nMis = 0;

    int ackDelay = 3;
    bit ackEn    = 1'b1;

    uart_cmd_rx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD),
        .ACK_TIMEOUT(1024)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rxd    (uart_rxd),
        .pc_cmd_valid(pc_cmd_valid),
        .pc_cmd_data (pc_cmd_data),
        .pc_ack      (pc_ack),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .ack_timeout (ack_timeout)
    );

    uart_cmd_rx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD),
        .ACK_TIMEOUT(TO_SHORT)
    ) dutTo (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rxd    (uart_rxd),
        .pc_cmd_valid(toValid),
        .pc_cmd_data (toData),
        .pc_ack      (ackTo),
        .frame_err   (toFerr),
        .overflow    (toOvf),
        .ack_timeout (toTimeout)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp observed pulses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every delivered byte and pulse, and tracks the
    // hold-until-next-strobe and minimum-spacing rules on the main DUT.
    logic [7:0] got[$];
    int         ferrN = 0;
    int         ovfN = 0;
    int         toN = 0;
    int         holdBad = 0;
    int         spaceBad = 0;
    int         lastValidCyc = -100;
    logic [7:0] lastData = 8'h00;
    int         tValidN = 0;
    int         tTimeoutN = 0;
    int         tValidCyc = 0;
    int         tTimeoutCyc = 0;
    int         tErrN = 0;
    logic [7:0] tData = 8'h00;

    always @(negedge clk) begin
        if (pc_cmd_valid) begin
            if (cyc - lastValidCyc < 2) spaceBad++;
            got.push_back(pc_cmd_data);
            lastValidCyc = cyc;
            lastData     = pc_cmd_data;
        end else if (!rst_n) begin
            lastData = 8'h00;
        end else if (pc_cmd_data !== lastData) begin
            holdBad++;
        end
        if (frame_err)   ferrN++;
        if (overflow)    ovfN++;
        if (ack_timeout) toN++;
        if (toValid) begin
            tValidN++;
            tValidCyc = cyc;
            tData     = toData;
        end
        if (toTimeout) begin
            tTimeoutN++;
            tTimeoutCyc = cyc;
        end
        if (toFerr || toOvf) tErrN++;
    end

    // Parser stand-in for the main DUT: acknowledges the outstanding byte
    // ackDelay cycles after its strobe, but only while ackEn is set.
    initial begin
        bit pend;
        int age;
        pc_ack = 1'b0;
        pend   = 1'b0;
        age    = 0;
        forever begin
            @(posedge clk);
            #1;
            pc_ack = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pc_cmd_valid) begin
                pend = 1'b1;
                age  = 0;
            end else if (pend) begin
                age++;
            end
            if (pend && ackEn && age >= ackDelay && age >= 1) begin
                pc_ack = 1'b1;
                pend   = 1'b0;
            end
        end
    end

    // Absolute time bound for the whole run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVec++;
        if (actual !== expected) begin
            nMis++;
            $display("[TB] FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        uart_rxd = b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame LSB first; the line returns high afterwards.
    task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input bit parOk);
        driveBit(1'b0);
        for (int b = 0; b < 8; b++) driveBit(data[b]);
        if (PAR_EN) driveBit((^data) ^ !parOk);
        driveBit(stopBit);
        uart_rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stopBit;
        int         expValid;
        int         expFerr;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] expQ[$];
    int         g0, f0, o0, t0, tv0, tt0, expErr, gap, nExp;
    logic [7:0] rd;
    bit         stopOk, parOk;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 1'b0, 0, 1};
        vecs[5] = '{8'h01, 1'b1, 1, 0};
        vecs[6] = '{8'h7E, 1'b1, 1, 0};

        uart_rxd = 1'b1;
        ackTo    = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset pc_cmd_valid", pc_cmd_valid, 0);
        checkOutput("reset pc_cmd_data", pc_cmd_data, 8'h00);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset ack_timeout", ack_timeout, 0);
        rst_n = 1'b1;
        idleCycles(5);

        // Timeout sequence on the short-timeout DUT; the main DUT acks the
        // same byte 3 cycles after its strobe.
        ackDelay = 3;
        g0 = got.size(); f0 = ferrN; tv0 = tValidN; tt0 = tTimeoutN;
        applyStimulus(8'h5A, 1'b1, 1'b1);
        idleCycles(40);
        checkOutput("timeout valid count", tValidN - tv0, 1);
        checkOutput("timeout valid data", tData, 8'h5A);
        checkOutput("timeout pulse count", tTimeoutN - tt0, 1);
        checkOutput("timeout latency", tTimeoutCyc - tValidCyc, TO_SHORT);
        applyStimulus(8'h11, 1'b1, 1'b1);
        idleCycles(40);
        checkOutput("after timeout valid count", tValidN - tv0, 2);
        checkOutput("after timeout data", tData, 8'h11);
        checkOutput("timeout dut error pulses", tErrN, 0);
        checkOutput("main dut byte count", got.size() - g0, 2);
        if (got.size() - g0 == 2) begin
            checkOutput("main dut byte 5A", got[g0], 8'h5A);
            checkOutput("main dut byte 11", got[g0+1], 8'h11);
        end
        checkOutput("main dut frame_err", ferrN - f0, 0);

        // Table of single frames.
        for (int i = 0; i < 7; i++) begin
            g0 = got.size(); f0 = ferrN; o0 = ovfN; t0 = toN;
            applyStimulus(vecs[i].data, vecs[i].stopBit, 1'b1);
            idleCycles(24);
            checkOutput($sformatf("vec%0d valid count", i), got.size() - g0, vecs[i].expValid);
            if (vecs[i].expValid == 1 && got.size() > g0)
                checkOutput($sformatf("vec%0d data", i), got[g0], vecs[i].data);
            checkOutput($sformatf("vec%0d frame_err", i), ferrN - f0, vecs[i].expFerr);
            checkOutput($sformatf("vec%0d overflow", i), ovfN - o0, 0);
            checkOutput($sformatf("vec%0d ack_timeout", i), toN - t0, 0);
        end

        // Short low glitch on the idle line.
        g0 = got.size(); f0 = ferrN; o0 = ovfN;
        uart_rxd = 1'b0;
        idleCycles(3);
        uart_rxd = 1'b1;
        idleCycles(200);
        checkOutput("glitch valid", got.size() - g0, 0);
        checkOutput("glitch frame_err", ferrN - f0, 0);
        checkOutput("glitch overflow", ovfN - o0, 0);

        // Six frames back to back with the parser stalled: the fifth byte
        // fills the FIFO behind the issued first one, the sixth overflows.
        ackEn = 1'b0; ackDelay = 1;
        g0 = got.size(); f0 = ferrN; o0 = ovfN;
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, 1'b1);
        checkOutput("fill overflow before 6th", ovfN - o0, 0);
        checkOutput("fill issued before ack", got.size() - g0, 1);
        applyStimulus(8'h06, 1'b1, 1'b1);
        checkOutput("fill overflow after 6th", ovfN - o0, 1);
        ackEn = 1'b1;
        idleCycles(100);
        checkOutput("fill delivered count", got.size() - g0, 5);
        for (int i = 0; i < 5; i++)
            if (g0 + i < got.size())
                checkOutput($sformatf("fill byte %0d", i), got[g0+i], i + 1);
        checkOutput("fill overflow final", ovfN - o0, 1);
        checkOutput("fill frame_err", ferrN - f0, 0);

        // Reset in the middle of bit 4 of 0xFF.
        ackDelay = 2;
        driveBit(1'b0);
        for (int b = 0; b < 4; b++) driveBit(1'b1);
        idleCycles(8);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset pc_cmd_data", pc_cmd_data, 8'h00);
        checkOutput("midreset pc_cmd_valid", pc_cmd_valid, 0);
        idleCycles(4);
        rst_n = 1'b1;
        g0 = got.size(); f0 = ferrN; o0 = ovfN; t0 = toN;
        idleCycles(120);
        checkOutput("post reset quiet valid", got.size() - g0, 0);
        checkOutput("post reset quiet frame_err", ferrN - f0, 0);
        checkOutput("post reset quiet overflow", ovfN - o0, 0);
        checkOutput("post reset quiet ack_timeout", toN - t0, 0);
        applyStimulus(8'h81, 1'b1, 1'b1);
        idleCycles(24);
        checkOutput("post reset 81 count", got.size() - g0, 1);
        if (got.size() > g0) checkOutput("post reset 81 data", got[g0], 8'h81);
        checkOutput("post reset 81 frame_err", ferrN - f0, 0);
`ifdef UART_RX_PARITY_EN
        g0 = got.size(); f0 = ferrN;
        applyStimulus(8'h81, 1'b1, 1'b0);
        idleCycles(24);
        checkOutput("parity 81 bad valid", got.size() - g0, 0);
        checkOutput("parity 81 bad frame_err", ferrN - f0, 1);
`endif

        // Random frame stream against a queue model of good bytes.
        ackDelay = $urandom_range(1, 6);
        g0 = got.size(); f0 = ferrN; o0 = ovfN; t0 = toN;
        expErr = 0;
        for (int n = 0; n < 40; n++) begin
            rd     = 8'($urandom);
            stopOk = ($urandom_range(0, 5) != 0);
            parOk  = PAR_EN ? ($urandom_range(0, 5) != 0) : 1'b1;
            applyStimulus(rd, stopOk, parOk);
            if (stopOk && parOk) expQ.push_back(rd);
            else expErr++;
            gap = stopOk ? $urandom_range(0, 20) : $urandom_range(4, 20);
            idleCycles(gap);
        end
        idleCycles(40);
        nExp = expQ.size();
        checkOutput("random byte count", got.size() - g0, nExp);
        for (int i = 0; i < nExp; i++)
            if (g0 + i < got.size())
                checkOutput($sformatf("random byte %0d", i), got[g0+i], expQ[i]);
        checkOutput("random frame_err", ferrN - f0, expErr);
        checkOutput("random overflow", ovfN - o0, 0);
        checkOutput("random ack_timeout", toN - t0, 0);

        checkOutput("data hold violations", holdBad, 0);
        checkOutput("valid spacing violations", spaceBad, 0);
        checkOutput("main ack_timeout total", toN, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
